hwpe_sel_switch: RTL and testbench

Run-time HWPE selection controller for the cluster HWPE subsystem, generalised to N_HWPES accelerators sharing one HCI master port and one config port. It replaces static `hwpe_sel_i` decoding with a safe switch. On a selection change or disable it blocks new TCDM requests from the active HWPE, waits for that HWPE to go idle and for all its outstanding TCDM transactions to retire, then moves the registered select and per-HWPE clock enables. It sits between the cluster control registers and the HWPE clock gates, the config-bus mux and the TCDM mux.

---
 rtl/hwpe_sel_switch.sv | 100 ++++++++++
 tb/tb_hwpe_sel_switch.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/hwpe_sel_switch.sv
// hwpe_sel_switch: run-time HWPE selection that drains outstanding TCDM traffic
// before moving the registered select and one-hot clock enables.
module hwpe_sel_switch #(
    parameter int N_HWPES         = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int SEL_W           = (N_HWPES > 1) ? $clog2(N_HWPES) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hwpe_en_i,
    input  logic [SEL_W-1:0]   hwpe_sel_i,
    input  logic [N_HWPES-1:0] hwpe_busy_i,
    input  logic               tcdm_req_i,
    output logic               tcdm_gnt_o,
    output logic               tcdm_req_o,
    input  logic               tcdm_gnt_i,
    input  logic               tcdm_r_valid_i,
    output logic [SEL_W-1:0]   sel_o,
    output logic [N_HWPES-1:0] clk_en_o,
    output logic               cfg_stall_o,
    output logic               busy_o,
    output logic               err_o
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWAP} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] req_sel;
    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             sel_valid;
    logic             block;
    logic             inc;
    logic             dec;
    logic             active;

    // An out-of-range select behaves as if the current selection were requested.
    assign sel_valid = 32'(hwpe_sel_i) < N_HWPES;
    assign req_sel   = sel_valid ? hwpe_sel_i : sel_q;

    assign block      = (state != RUN) || (cnt == CNT_W'(MAX_OUTSTANDING));
    assign tcdm_req_o = tcdm_req_i & ~block;
    assign tcdm_gnt_o = tcdm_gnt_i & ~block;
    assign inc        = tcdm_req_o & tcdm_gnt_i;
    assign dec        = tcdm_r_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hwpe_en_i && sel_valid) begin
                        sel_q <= hwpe_sel_i;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!hwpe_en_i || req_sel != sel_q)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (hwpe_en_i && req_sel == sel_q)
                        state <= RUN;
                    else if (cnt == '0 && !hwpe_busy_i[sel_q]) begin
                        if (!hwpe_en_i)
                            state <= IDLE;
                        else begin
                            sel_q <= req_sel;
                            state <= SWAP;
                        end
                    end
                end
                SWAP:    state <= RUN;
                default: state <= IDLE;
            endcase
            // A response with nothing outstanding saturates at zero and flags an error.
            if (inc && !dec)
                cnt <= cnt + CNT_W'(1);
            else if (dec && !inc) begin
                if (cnt == '0)
                    err_q <= 1'b1;
                else
                    cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign active      = (state == RUN) || (state == DRAIN);
    assign clk_en_o    = active ? (N_HWPES'(1) << sel_q) : '0;
    assign cfg_stall_o = (state == DRAIN) || (state == SWAP);
    assign busy_o      = (state != IDLE) && (hwpe_busy_i[sel_q] || cnt != '0 || state != RUN);
    assign sel_o       = sel_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_hwpe_sel_switch.sv
// tb_hwpe_sel_switch: table-driven check of selection switching, draining,
// outstanding limit, invalid select and underflow error.
module tb_hwpe_sel_switch;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       hwpe_en_i;
    logic [1:0] hwpe_sel_i;
    logic [1:0] hwpe_busy_i;
    logic       tcdm_req_i;
    logic       tcdm_gnt_o;
    logic       tcdm_req_o;
    logic       tcdm_gnt_i;
    logic       tcdm_r_valid_i;
    logic [1:0] sel_o;
    logic [1:0] clk_en_o;
    logic       cfg_stall_o;
    logic       busy_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [1:0] sel;
        logic [1:0] busy;
        logic       req;
        logic       gnt;
        logic       rv;
        logic       e_req;
        logic       e_gnt;
        logic [1:0] e_sel;
        logic [1:0] e_clk;
        logic       e_stall;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    vec_t vt[$];
    vec_t sb[$];

    hwpe_sel_switch #(.N_HWPES(2), .MAX_OUTSTANDING(8), .SEL_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .hwpe_en_i(hwpe_en_i), .hwpe_sel_i(hwpe_sel_i),
        .hwpe_busy_i(hwpe_busy_i), .tcdm_req_i(tcdm_req_i), .tcdm_gnt_o(tcdm_gnt_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .sel_o(sel_o), .clk_en_o(clk_en_o), .cfg_stall_o(cfg_stall_o), .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int en, int sel, int busy, int req, int gnt, int rv,
                                int e_req, int e_gnt, int e_sel, int e_clk,
                                int e_stall, int e_busy, int e_err);
        vec_t v;
        v.en = 1'(en); v.sel = 2'(sel); v.busy = 2'(busy);
        v.req = 1'(req); v.gnt = 1'(gnt); v.rv = 1'(rv);
        v.e_req = 1'(e_req); v.e_gnt = 1'(e_gnt); v.e_sel = 2'(e_sel);
        v.e_clk = 2'(e_clk); v.e_stall = 1'(e_stall); v.e_busy = 1'(e_busy);
        v.e_err = 1'(e_err);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] sel, input logic [1:0] busy,
                         input logic req, input logic gnt, input logic rv);
        hwpe_en_i = en; hwpe_sel_i = sel; hwpe_busy_i = busy;
        tcdm_req_i = req; tcdm_gnt_i = gnt; tcdm_r_valid_i = rv;
    endtask

    task automatic chk_regs(input string name, input logic [1:0] s, input logic [1:0] c,
                            input logic st, input logic b, input logic e);
        chk(name, {24'd0, sel_o, clk_en_o, cfg_stall_o, busy_o, err_o}, {24'd0, s, c, st, b, e});
    endtask

    // Expected record is queued at drive time and retired after the edge it describes.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        drive(v.en, v.sel, v.busy, v.req, v.gnt, v.rv);
        sb.push_back(v);
        #1;
        chk($sformatf("row%0d_req_gnt", idx), {30'd0, tcdm_req_o, tcdm_gnt_o},
            {30'd0, sb[0].e_req, sb[0].e_gnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_regs($sformatf("row%0d_regs", idx), e.e_sel, e.e_clk, e.e_stall, e.e_busy, e.e_err);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 2'd1, 2'b11, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_regs("reset_regs", 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("reset_req_gnt", {30'd0, tcdm_req_o, tcdm_gnt_o}, 32'd0);
        @(negedge clk);
        drive(1'b0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // en sel busy req gnt rv | req_o gnt_o | sel clk_en stall busy err
        vt.push_back(mk(1, 1, 'b00, 1, 1, 0, 0, 0, 1, 'b10, 0, 0, 0));
        vt.push_back(mk(1, 1, 'b10, 0, 0, 0, 0, 0, 1, 'b10, 0, 1, 0));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(1, 1, 'b10, 1, 1, 0, 1, 1, 1, 'b10, 0, 1, 0));
        vt.push_back(mk(1, 0, 'b10, 0, 0, 0, 0, 0, 1, 'b10, 1, 1, 0));
        for (int i = 0; i < 3; i++)
            vt.push_back(mk(1, 0, 'b10, 1, 1, 1, 0, 0, 1, 'b10, 1, 1, 0));
        vt.push_back(mk(1, 0, 'b10, 0, 0, 0, 0, 0, 1, 'b10, 1, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 0, 0, 0, 0, 0, 0, 'b00, 1, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 0, 0, 0, 0, 0, 0, 'b01, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vt.push_back(mk(1, 0, 'b00, 1, 1, 0, 1, 1, 0, 'b01, 0, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 1, 1, 0, 0, 0, 0, 'b01, 0, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 1, 1, 1, 0, 0, 0, 'b01, 0, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 1, 1, 0, 1, 1, 0, 'b01, 0, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 1, 1, 0, 0, 0, 0, 'b01, 0, 1, 0));
        for (int i = 0; i < 6; i++)
            vt.push_back(mk(1, 0, 'b00, 0, 0, 1, 0, 0, 0, 'b01, 0, 1, 0));
        vt.push_back(mk(1, 1, 'b00, 0, 0, 0, 0, 0, 0, 'b01, 1, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 0, 0, 0, 0, 0, 0, 'b01, 0, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 0, 0, 1, 0, 0, 0, 'b01, 0, 1, 0));
        vt.push_back(mk(1, 0, 'b00, 0, 0, 1, 0, 0, 0, 'b01, 0, 0, 0));
        vt.push_back(mk(0, 0, 'b01, 0, 0, 0, 0, 0, 0, 'b01, 1, 1, 0));
        vt.push_back(mk(0, 0, 'b01, 0, 0, 0, 0, 0, 0, 'b01, 1, 1, 0));
        vt.push_back(mk(0, 0, 'b00, 0, 0, 0, 0, 0, 0, 'b00, 0, 0, 0));
        vt.push_back(mk(1, 3, 'b00, 0, 0, 0, 0, 0, 0, 'b00, 0, 0, 0));
        vt.push_back(mk(1, 1, 'b00, 0, 0, 0, 0, 0, 1, 'b10, 0, 0, 0));
        vt.push_back(mk(1, 3, 'b00, 0, 0, 0, 0, 0, 1, 'b10, 0, 0, 0));
        vt.push_back(mk(1, 2, 'b00, 0, 0, 0, 0, 0, 1, 'b10, 0, 0, 0));
        vt.push_back(mk(1, 1, 'b00, 0, 0, 1, 0, 0, 1, 'b10, 0, 0, 1));
        vt.push_back(mk(1, 1, 'b00, 0, 0, 0, 0, 0, 1, 'b10, 0, 0, 1));
        vt.push_back(mk(1, 1, 'b00, 1, 1, 1, 1, 1, 1, 'b10, 0, 0, 1));
        vt.push_back(mk(1, 1, 'b00, 1, 1, 0, 1, 1, 1, 'b10, 0, 1, 1));

        foreach (vt[i]) apply(vt[i], i);

        // Asynchronous reset while a transaction is outstanding, then a stray response.
        @(negedge clk);
        drive(1'b1, 2'd1, 2'b10, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_regs("async_reset_regs", 2'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'd0, 2'b00, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_regs("stray_resp_err", 2'd0, 2'b00, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
